// File: rtl/con_eval_unit.sv
// Branch-condition evaluator: captures Ra and C2, evaluates the condition,
// holds the result until acknowledged, and counts evaluations and taken outcomes.
module con_eval_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [2:0]       cond,
  input  logic             con_in,
  input  logic             con_ack,
  input  logic             stat_clr,
  output logic             CON,
  output logic             con_valid,
  output logic             busy,
  output logic [CNT_W-1:0] eval_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [2:0]       c_q, c_d;
  logic             con_q, con_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] ev_q, ev_d;
  logic [CNT_W-1:0] tk_q, tk_d;
  logic             res;
  logic             zero;
  logic             neg;

  // Decode the captured condition against the captured operand (signed).
  always_comb begin
    zero = (x_q == '0);
    neg  = x_q[WIDTH-1];
    res  = 1'b0;
    case (c_q)
      3'b000: res = zero;
      3'b001: res = !zero;
      3'b010: res = !zero && !neg;
      3'b011: res = neg;
      3'b100: res = !neg;
      3'b101: res = zero || neg;
      3'b110: res = 1'b1;
      default: res = 1'b0;
    endcase
  end

  // Next-state for the FSM, operand capture and the result register.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    c_d     = c_q;
    con_d   = con_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (con_in) begin
          x_d     = bus_in;
          c_d     = cond;
          state_d = EVAL;
        end
      end
      EVAL: begin
        con_d   = res;
        vld_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (con_ack) begin
          vld_d = 1'b0;
          if (con_in) begin
            x_d     = bus_in;
            c_d     = cond;
            state_d = EVAL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Saturating statistics; a clear request wins over a same-edge count.
  always_comb begin
    ev_d = ev_q;
    tk_d = tk_q;
    if (stat_clr) begin
      ev_d = '0;
      tk_d = '0;
    end else if (state_q == EVAL) begin
      if (ev_q != MAX) ev_d = ev_q + ONE;
      if (res && (tk_q != MAX)) tk_d = tk_q + ONE;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      x_q     <= '0;
      c_q     <= '0;
      con_q   <= 1'b0;
      vld_q   <= 1'b0;
      ev_q    <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      c_q     <= c_d;
      con_q   <= con_d;
      vld_q   <= vld_d;
      ev_q    <= ev_d;
      tk_q    <= tk_d;
    end
  end

  assign CON       = con_q;
  assign con_valid = vld_q;
  assign busy      = (state_q != IDLE);
  assign eval_cnt  = ev_q;
  assign taken_cnt = tk_q;

endmodule

// File: tb/tb_con_eval_unit.sv
// Randomized self-checking bench for con_eval_unit with a transaction-level
// model, plus directed scenarios pinned to hand-computed values.
module tb_con_eval_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] bus_in = '0;
  logic [2:0]  cond = '0;
  logic        con_in = 1'b0;
  logic        con_ack = 1'b0;
  logic        stat_clr = 1'b0;

  logic        con_a, vld_a, busy_a;
  logic [15:0] ev_a, tk_a;
  logic        con_b, vld_b, busy_b;
  logic [1:0]  ev_b, tk_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  con_eval_unit #(.WIDTH(32), .CNT_W(16)) dut_a (
    .clock(clock), .clear(clear), .bus_in(bus_in), .cond(cond),
    .con_in(con_in), .con_ack(con_ack), .stat_clr(stat_clr),
    .CON(con_a), .con_valid(vld_a), .busy(busy_a),
    .eval_cnt(ev_a), .taken_cnt(tk_a)
  );

  con_eval_unit #(.WIDTH(32), .CNT_W(2)) dut_b (
    .clock(clock), .clear(clear), .bus_in(bus_in), .cond(cond),
    .con_in(con_in), .con_ack(con_ack), .stat_clr(stat_clr),
    .CON(con_b), .con_valid(vld_b), .busy(busy_b),
    .eval_cnt(ev_b), .taken_cnt(tk_b)
  );

  always #5 clock = ~clock;

  function automatic bit evalf(input logic [31:0] x, input logic [2:0] c);
    longint s;
    s = longint'($signed(x));
    case (c)
      3'd0: return s == 0;
      3'd1: return s != 0;
      3'd2: return s > 0;
      3'd3: return s < 0;
      3'd4: return s >= 0;
      3'd5: return s <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model: a request is either in flight, or a result is awaiting ack.
  bit          m_fly, m_vld, m_con;
  logic [31:0] m_x;
  logic [2:0]  m_c;
  int          m_ev, m_tk;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_fly <= 1'b0;
      m_vld <= 1'b0;
      m_con <= 1'b0;
      m_x   <= '0;
      m_c   <= '0;
      m_ev  <= 0;
      m_tk  <= 0;
    end else begin
      if (m_fly) begin
        m_con <= evalf(m_x, m_c);
        m_vld <= 1'b1;
        m_fly <= 1'b0;
      end else if (con_in && (!m_vld || con_ack)) begin
        m_x   <= bus_in;
        m_c   <= cond;
        m_fly <= 1'b1;
        m_vld <= 1'b0;
      end else if (m_vld && con_ack) begin
        m_vld <= 1'b0;
      end
      if (stat_clr) begin
        m_ev <= 0;
        m_tk <= 0;
      end else if (m_fly) begin
        m_ev <= m_ev + 1;
        if (evalf(m_x, m_c)) m_tk <= m_tk + 1;
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("con_a", 32'(con_a), 32'(m_con));
      chk("vld_a", 32'(vld_a), 32'(m_vld));
      chk("busy_a", 32'(busy_a), 32'(m_fly || m_vld));
      chk("ev_a", 32'(ev_a), 32'(sat(m_ev, 65535)));
      chk("tk_a", 32'(tk_a), 32'(sat(m_tk, 65535)));
      chk("con_b", 32'(con_b), 32'(m_con));
      chk("vld_b", 32'(vld_b), 32'(m_vld));
      chk("busy_b", 32'(busy_b), 32'(m_fly || m_vld));
      chk("ev_b", 32'(ev_b), 32'(sat(m_ev, 3)));
      chk("tk_b", 32'(tk_b), 32'(sat(m_tk, 3)));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_eval(input logic [31:0] x, input logic [2:0] c,
                         output logic r);
    bus_in = x;
    cond   = c;
    con_in = 1'b1;
    cyc();
    con_in = 1'b0;
    cyc();
    r = con_a;
    con_ack = 1'b1;
    cyc();
    con_ack = 1'b0;
  endtask

  logic r;

  initial begin
    #1 clear = 1'b1;
    #1;
    cmp_en = 1'b1;
    chk("rst_con", 32'(con_a), 0);
    chk("rst_vld", 32'(vld_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_ev", 32'(ev_a), 0);
    #10 clear = 1'b0;
    cyc();

    // Zero test
    bus_in = 32'd0; cond = 3'b000; con_in = 1'b1;
    cyc();
    con_in = 1'b0;
    bus_in = 32'd7;
    cyc();
    chk("zero_con", 32'(con_a), 1);
    chk("zero_vld", 32'(vld_a), 1);
    chk("zero_ev", 32'(ev_a), 1);
    chk("zero_tk", 32'(tk_a), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("zero_hold_con", 32'(con_a), 1);
      chk("zero_hold_vld", 32'(vld_a), 1);
    end
    con_ack = 1'b1;
    cyc();
    con_ack = 1'b0;
    chk("ack_vld", 32'(vld_a), 0);
    chk("ack_retain", 32'(con_a), 1);
    chk("ack_idle", 32'(busy_a), 0);

    // Signed boundaries
    do_eval(32'h8000_0000, 3'b010, r); chk("min_gt", 32'(r), 0);
    do_eval(32'h8000_0000, 3'b011, r); chk("min_lt", 32'(r), 1);
    do_eval(32'h7FFF_FFFF, 3'b010, r); chk("max_gt", 32'(r), 1);
    do_eval(32'h0000_0000, 3'b101, r); chk("zero_le", 32'(r), 1);
    do_eval(32'h0000_0000, 3'b111, r); chk("never", 32'(r), 0);

    // Back-to-back
    bus_in = 32'd0; cond = 3'b111; con_in = 1'b1;
    cyc();
    con_in = 1'b0;
    cyc();
    chk("b2b_first", 32'(con_a), 0);
    bus_in = 32'd5; cond = 3'b001; con_in = 1'b1; con_ack = 1'b1;
    cyc();
    con_in = 1'b0; con_ack = 1'b0;
    chk("b2b_gap_vld", 32'(vld_a), 0);
    chk("b2b_gap_busy", 32'(busy_a), 1);
    cyc();
    chk("b2b_con", 32'(con_a), 1);
    chk("b2b_vld", 32'(vld_a), 1);
    con_ack = 1'b1;
    cyc();
    con_ack = 1'b0;

    // Saturation and stat clear
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    for (int i = 0; i < 5; i++) do_eval($urandom, 3'b110, r);
    chk("sat_ev_b", 32'(ev_b), 3);
    chk("sat_tk_b", 32'(tk_b), 3);
    chk("sat_ev_a", 32'(ev_a), 5);
    bus_in = 32'd0; cond = 3'b110; con_in = 1'b1;
    cyc();
    con_in = 1'b0; stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    chk("sclr_ev_a", 32'(ev_a), 0);
    chk("sclr_tk_b", 32'(tk_b), 0);
    chk("sclr_vld", 32'(vld_a), 1);
    chk("sclr_con", 32'(con_a), 1);
    con_ack = 1'b1;
    cyc();
    con_ack = 1'b0;

    // Mid-operation reset
    do_eval(32'd3, 3'b010, r);
    bus_in = 32'd0; cond = 3'b110; con_in = 1'b1;
    cyc();
    con_in = 1'b0;
    #1 clear = 1'b1;
    #1;
    chk("mid_con", 32'(con_a), 0);
    chk("mid_vld", 32'(vld_a), 0);
    chk("mid_busy", 32'(busy_a), 0);
    chk("mid_ev", 32'(ev_a), 0);
    clear = 1'b0;
    cyc();
    bus_in = 32'hFFFF_FFF0; cond = 3'b100; con_in = 1'b1;
    cyc();
    con_in = 1'b0;
    chk("post_lat_vld", 32'(vld_a), 0);
    cyc();
    chk("post_vld", 32'(vld_a), 1);
    chk("post_con", 32'(con_a), 0);
    chk("post_ev", 32'(ev_a), 1);
    con_ack = 1'b1;
    cyc();
    con_ack = 1'b0;

    // Ignored inputs
    bus_in = 32'hFFFF_FFFF; cond = 3'b011; con_in = 1'b1;
    cyc();
    bus_in = 32'd0; cond = 3'b111;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus_in = $urandom;
      cyc();
    end
    chk("ign_ev", 32'(ev_a), 2);
    chk("ign_con", 32'(con_a), 1);
    chk("ign_vld", 32'(vld_a), 1);
    con_in = 1'b0; con_ack = 1'b1;
    cyc();
    con_ack = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: bus_in = 32'h0;
        1: bus_in = 32'h8000_0000;
        2: bus_in = 32'h7FFF_FFFF;
        3: bus_in = 32'hFFFF_FFFF;
        4: bus_in = 32'h1;
        default: bus_in = $urandom;
      endcase
      cond     = 3'($urandom_range(0, 7));
      con_in   = ($urandom_range(0, 2) != 0);
      con_ack  = ($urandom_range(0, 2) == 0);
      stat_clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #1 clear = 1'b1;
        #1 clear = 1'b0;
      end
      cyc();
    end
    con_in = 1'b0; con_ack = 1'b0; stat_clr = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/con_eval_unit.md
CON_EVAL_UNIT -- requirements
Module: con_eval_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (min 2).
REQ-002 SHALL have parameter CNT_W, default 16, statistics counter width in bits.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clear  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port bus_in  in  WIDTH  operand, Ra value from bus.
REQ-006 SHALL have port cond  in  3  condition code, IR C2 field extended to 3 bits.
REQ-007 SHALL have port con_in  in  1  evaluation request, sampled on a clock edge.
REQ-008 SHALL have port con_ack  in  1  consumer acknowledge of the result.
REQ-009 SHALL have port stat_clr  in  1  synchronous clear of statistics counters.
REQ-010 SHALL have port CON  out  1  registered branch-condition result.
REQ-011 SHALL have port con_valid  out  1  CON holds a fresh result awaiting acknowledge.
REQ-012 SHALL have port busy  out  1  high in EVAL and HOLD.
REQ-013 SHALL have port eval_cnt  out  CNT_W  number of completed evaluations.
REQ-014 SHALL have port taken_cnt  out  CNT_W  number of evaluations with CON=1.

Function
REQ-015 SHALL implement FSM states IDLE, EVAL and HOLD, and SHALL reset to IDLE.
REQ-016 In IDLE, con_in=1 SHALL capture bus_in and cond into internal registers and move to EVAL.
REQ-017 In IDLE, con_in=0 SHALL leave the unit in IDLE with no state change.
REQ-018 In EVAL, the edge SHALL load CON from the captured operand and cond, set con_valid=1, update the counters and move to HOLD.
REQ-019 Condition decode SHALL use the captured operand x, signed two's complement with MSB as sign:
- 000: x==0
- 001: x!=0
- 010: x>0
- 011: x<0
- 100: x>=0
- 101: x<=0
- 110: 1 (always)
- 111: 0 (never)
REQ-020 Latency SHALL be fixed: con_in sampled at edge N gives CON and con_valid valid after edge N+1.
REQ-021 In HOLD, CON and con_valid SHALL stay constant until con_ack=1 is sampled.
REQ-022 In HOLD, con_ack=1 with con_in=0 SHALL clear con_valid and move to IDLE.
REQ-023 In HOLD, con_ack=1 with con_in=1 SHALL clear con_valid, capture new operands and move to EVAL (back-to-back).
REQ-024 con_in SHALL be ignored in EVAL, and in HOLD while con_ack=0; no capture, no error.
REQ-025 con_ack SHALL be ignored in IDLE and EVAL.
REQ-026 CON SHALL retain its last value after acknowledge until the next EVAL edge.
REQ-027 Operand changes on bus_in after the capture edge SHALL NOT affect CON.
REQ-028 eval_cnt SHALL increment by 1 on every EVAL edge.
REQ-029 taken_cnt SHALL increment by 1 on an EVAL edge where the new CON=1.
REQ-030 Both counters SHALL saturate at all-ones and never wrap.
REQ-031 stat_clr=1 SHALL zero both counters on the edge, with priority over a same-edge increment; FSM, CON and con_valid SHALL be unaffected.
REQ-032 busy SHALL be combinational from state: 0 in IDLE, 1 in EVAL and HOLD.

Reset
REQ-033 clear=1 SHALL immediately and asynchronously force the following, regardless of clock:
- state=IDLE
- CON=0, con_valid=0
- eval_cnt=0, taken_cnt=0
- captured operand and cond registers = 0
REQ-034 clear asserted in EVAL or HOLD SHALL abort the evaluation; no counter update SHALL occur for that request.
REQ-035 After clear deasserts, the first con_in=1 sampled SHALL be processed normally.

Verification
REQ-036 Zero test:
- stimulus: bus_in=0, cond=000, con_in pulse, con_ack held 0
- response: after 2 edges CON=1, con_valid=1, eval_cnt=1, taken_cnt=1; CON and con_valid held for 5 further cycles.
REQ-037 Signed boundaries (WIDTH=32):
- bus_in=0x80000000, cond=010 -> CON=0
- cond=011 -> CON=1
- bus_in=0x7FFFFFFF, cond=010 -> CON=1
- bus_in=0, cond=101 -> CON=1
REQ-038 Back-to-back:
- stimulus: in HOLD, con_ack=1 and con_in=1 on the same edge, with bus_in=5, cond=001
- response: next edge EVAL, following edge CON=1, con_valid=1; con_valid low for exactly one cycle.
REQ-039 Saturation and clear (CNT_W=2):
- stimulus: 5 evaluations with cond=110
- response: eval_cnt=3 and taken_cnt=3, held at saturation.
- stimulus: stat_clr asserted on an EVAL edge
- response: both counters=0.
REQ-040 Mid-operation reset:
- stimulus: clear pulsed while in EVAL
- response: immediately CON=0, con_valid=0, busy=0, counters=0; next request completes with 2-edge latency.
REQ-041 Ignored inputs:
- stimulus: con_in=1 during EVAL and during HOLD with con_ack=0, with bus_in toggled
- response: no extra eval_cnt increment; CON unchanged.
